neuron_out_layer: RTL and testbench

// - Output layer of the fixed-point MLP: 2 hidden activations in, 9 output neurons out.
// - Each neuron k computes y_k = W_k1*a2_1 + W_k2*a2_2 + B_k, saturates, then applies the optional ReLU.
// - Weights and biases are elaboration-time constants. Sits after the hidden layer (a2_*).
// - Results are registered: one clock of latency.

---
 rtl/neuron_out_layer.sv | 111 +++++++++++
 tb/tb_neuron_out_layer.sv | 116 +++++++++++
 2 files changed

// File: rtl/neuron_out_layer.sv
// Output layer of the fixed-point MLP: nine parallel neurons, 2 activations in, one registered stage.
// Optional ReLU on every neuron is enabled by defining NEURON_OUT_RELU_EN.
module neuron_out_lane #(
  parameter int DW   = 20,
  parameter int FRAC = 16,
  parameter logic signed [DW-1:0] W1 = '0,
  parameter logic signed [DW-1:0] W2 = '0,
  parameter logic signed [DW-1:0] B  = '0
) (
  input  logic signed [DW-1:0] a1,
  input  logic signed [DW-1:0] a2,
  output logic        [DW-1:0] y
);
  // Two guard bits above the full product width: the three-term sum can never wrap.
  localparam int SW = 2*DW + 2;
  localparam logic signed [SW-1:0] SMAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [2*DW-1:0] p1, p2;
  logic signed [SW-1:0]   e1, e2, eb, s;
  logic        [DW-1:0]   sat;

  assign p1 = W1 * a1;
  assign p2 = W2 * a2;
  assign e1 = $signed({{2{p1[2*DW-1]}}, p1}) >>> FRAC;
  assign e2 = $signed({{2{p2[2*DW-1]}}, p2}) >>> FRAC;
  assign eb = $signed({{(SW-DW){B[DW-1]}}, B});
  assign s  = e1 + e2 + eb;

  always_comb begin
    sat = s[DW-1:0];
    if (s > SMAX)      sat = {1'b0, {(DW-1){1'b1}}};
    else if (s < SMIN) sat = {1'b1, {(DW-1){1'b0}}};
  end

`ifdef NEURON_OUT_RELU_EN
  assign y = sat[DW-1] ? '0 : sat;
`else
  assign y = sat;
`endif
endmodule

module neuron_out_layer #(
  parameter int DW   = 20,
  parameter int FRAC = 16,
  // W_k1 = k/8, W_k2 = -k/16, packed lowest neuron first
  parameter logic [18*DW-1:0] WEIGHTS = {
    20'hF7000, 20'h12000, 20'hF8000, 20'h10000, 20'hF9000, 20'h0E000,
    20'hFA000, 20'h0C000, 20'hFB000, 20'h0A000, 20'hFC000, 20'h08000,
    20'hFD000, 20'h06000, 20'hFE000, 20'h04000, 20'hFF000, 20'h02000},
  parameter logic [9*DW-1:0]  BIASES  = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] a2_1,
  input  logic [DW-1:0] a2_2,
  output logic          out_valid,
  output logic [DW-1:0] a3_1,
  output logic [DW-1:0] a3_2,
  output logic [DW-1:0] a3_3,
  output logic [DW-1:0] a3_4,
  output logic [DW-1:0] a3_5,
  output logic [DW-1:0] a3_6,
  output logic [DW-1:0] a3_7,
  output logic [DW-1:0] a3_8,
  output logic [DW-1:0] a3_9
);
  localparam int NUM_LANES = 9;
  localparam int STAGES    = 1;

  logic [NUM_LANES-1:0][DW-1:0] y_d, a3_q;
  logic [STAGES:0]              vld_pipe;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    neuron_out_lane #(
      .DW(DW), .FRAC(FRAC),
      .W1(WEIGHTS[(2*k)*DW +: DW]),
      .W2(WEIGHTS[(2*k+1)*DW +: DW]),
      .B (BIASES[k*DW +: DW])
    ) u_lane (
      .a1(a2_1),
      .a2(a2_2),
      .y (y_d[k])
    );
  end

  assign vld_pipe[0] = in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      a3_q               <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      // Outputs hold their last result across idle cycles.
      if (in_valid) a3_q <= y_d;
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign a3_1 = a3_q[0];
  assign a3_2 = a3_q[1];
  assign a3_3 = a3_q[2];
  assign a3_4 = a3_q[3];
  assign a3_5 = a3_q[4];
  assign a3_6 = a3_q[5];
  assign a3_7 = a3_q[6];
  assign a3_8 = a3_q[7];
  assign a3_9 = a3_q[8];
endmodule

// File: tb/tb_neuron_out_layer.sv
// Randomized bench for neuron_out_layer against an integer-arithmetic reference model.
module tb_neuron_out_layer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [19:0] a2_1, a2_2;
  logic        out_valid;
  logic [19:0] a3 [9];

  int n_cmp = 0;
  int n_bad = 0;

  logic [19:0] exp_a3 [9];
  logic        exp_vld;

  neuron_out_layer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a2_1(a2_1), .a2_2(a2_2),
    .out_valid(out_valid),
    .a3_1(a3[0]), .a3_2(a3[1]), .a3_3(a3[2]), .a3_4(a3[3]), .a3_5(a3[4]),
    .a3_6(a3[5]), .a3_7(a3[6]), .a3_8(a3[7]), .a3_9(a3[8])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
    end
  endtask

  // Neuron k (1..9): y = floor(k/8 * x1) + floor(-k/16 * x2) in Q.16, saturated, optional ReLU.
  function automatic logic [19:0] ref_out(input int k, input logic [19:0] x1, input logic [19:0] x2);
    longint v1, v2, s;
    v1 = longint'($signed(x1));
    v2 = longint'($signed(x2));
    s  = ((longint'(k) * 8192 * v1) >>> 16) + ((longint'(-k) * 4096 * v2) >>> 16);
    if (s > 524287)  s = 524287;
    if (s < -524288) s = -524288;
`ifdef NEURON_OUT_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[19:0];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "/out_valid"}, {31'd0, out_valid}, {31'd0, exp_vld});
    for (int k = 0; k < 9; k++)
      chk($sformatf("%s/a3_%0d", tag, k + 1), {12'd0, a3[k]}, {12'd0, exp_a3[k]});
  endtask

  task automatic step(input logic v, input logic [19:0] x1, input logic [19:0] x2, input string tag);
    @(negedge clk);
    in_valid = v; a2_1 = x1; a2_2 = x2;
    @(posedge clk);
    #1;
    exp_vld = v;
    if (v) for (int k = 0; k < 9; k++) exp_a3[k] = ref_out(k + 1, x1, x2);
    check_all(tag);
  endtask

  task automatic clear_model();
    exp_vld = 1'b0;
    for (int k = 0; k < 9; k++) exp_a3[k] = '0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a2_1 = '0; a2_2 = '0;
    clear_model();
    // Reset held with toggling inputs: outputs stay zero at and between edges.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a2_1 = 20'($urandom); a2_2 = 20'($urandom);
      #1 check_all("rst_mid");
      @(posedge clk); #1 check_all("rst_edge");
    end
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;

    step(1'b1, 20'h05AF4, 20'hFED26, "nominal");
    chk("nominal_a3_1_const", {12'd0, a3[0]}, 32'h00C8B);
    chk("nominal_a3_9_const", {12'd0, a3[8]}, 32'h070EC);
    step(1'b1, 20'h00000, 20'h00000, "zero");
    step(1'b1, 20'h7FFFF, 20'h00000, "sat");
    chk("sat_a3_9_const", {12'd0, a3[8]}, 32'h7FFFF);
    chk("sat_a3_1_const", {12'd0, a3[0]}, 32'h0FFFF);
    step(1'b1, 20'h80000, 20'h7FFFF, "sat_neg");
    step(1'b1, 20'hF0000, 20'h00000, "neg");
`ifdef NEURON_OUT_RELU_EN
    chk("neg_a3_1_const", {12'd0, a3[0]}, 32'h00000);
    chk("neg_a3_9_const", {12'd0, a3[8]}, 32'h00000);
`else
    chk("neg_a3_1_const", {12'd0, a3[0]}, 32'hFE000);
    chk("neg_a3_9_const", {12'd0, a3[8]}, 32'hEE000);
`endif
    step(1'b0, 20'($urandom), 20'($urandom), "gap_hold");
    step(1'b0, 20'($urandom), 20'($urandom), "gap_hold2");

    // Random stream: mostly back-to-back valids, some gaps, occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; a2_1 = 20'($urandom); a2_2 = 20'($urandom);
        clear_model();
        #1 check_all("rst_async");
        @(posedge clk); #1 check_all("rst_ignore_valid");
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
      end else begin
        step($urandom_range(0, 3) != 0, 20'($urandom), 20'($urandom), "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
